servo_ctrl: RTL and testbench

Position sequencer for the servo PWM generator. Accepts target-angle commands over a valid/ready handshake, converts angle to a pulse width in clock cycles, and slews the `duty` word driven into the PWM block by a bounded step once per 20 ms servo frame. All `duty` changes land exactly on the frame boundary, so the PWM output never emits a truncated or stretched pulse.

---
 rtl/servo_ctrl.sv | 140 ++++++++++++++
 tb/tb_servo_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_ctrl.sv
// servo_ctrl: position sequencer for the servo PWM generator.
// Accepts target angles over valid/ready, converts them to a pulse width in clock cycles and
// moves the PWM duty word toward the target once per servo frame, only on frame boundaries.
// Build option: define SERVO_CTRL_SLEW_EN to limit each per-frame move to SLEW_STEP cycles;
// without it the first enabled frame tick of a move jumps straight to the target.
module servo_ctrl #(
  parameter int unsigned CLK_IN      = 50_000_000,
  parameter int unsigned FREQ_SERVO  = 50,
  parameter int unsigned MIN_PULSE   = 50_000,
  parameter int unsigned MAX_PULSE   = 100_000,
  parameter int unsigned SLEW_STEP   = 1_000,
  parameter int unsigned RESET_ANGLE = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  output logic [17:0] duty,
  output logic        busy,
  output logic        at_target,
  output logic        frame_tick
);

  localparam int unsigned TOTAL_PERIOD = CLK_IN / FREQ_SERVO;
  localparam int unsigned STEP         = (MAX_PULSE - MIN_PULSE) / 180;

  localparam logic [17:0] MinPulseW  = 18'(MIN_PULSE);
  localparam logic [17:0] StepW      = 18'(STEP);
  localparam logic [17:0] ResetPulse = 18'(MIN_PULSE + RESET_ANGLE * STEP);
  localparam logic [19:0] LastCount  = 20'(TOTAL_PERIOD - 1);

`ifdef SERVO_CTRL_SLEW_EN
  localparam bit SlewEn = 1'b1;
`else
  localparam bit SlewEn = 1'b0;
`endif
  // Without slew limiting the step bound is the full range, so one step always lands on target.
  localparam logic [17:0] SlewLim = SlewEn ? 18'(SLEW_STEP) : 18'h3FFFF;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRamp = 2'd2;

  logic [19:0] count_q, count_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  angle_q, angle_d;
  logic [17:0] pos_q, pos_d;
  logic [17:0] tgt_q, tgt_d;
  logic [17:0] duty_q, duty_d;

  logic [7:0]  angle_clamp;
  logic [17:0] tgt_calc;
  logic        tgt_above;
  logic [17:0] diff;
  logic [17:0] step;
  logic [17:0] pos_step;

  // Frame counter: wraps after the last cycle of each frame, in lockstep with the PWM block.
  always_comb begin
    frame_tick = (count_q == LastCount);
    count_d    = frame_tick ? 20'd0 : count_q + 20'd1;
  end

  // Angle-to-pulse conversion and bounded step toward the target.
  always_comb begin
    angle_clamp = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;
    tgt_calc    = MinPulseW + 18'(angle_q) * StepW;
    tgt_above   = (tgt_q >= pos_q);
    diff        = tgt_above ? (tgt_q - pos_q) : (pos_q - tgt_q);
    step        = (diff > SlewLim) ? SlewLim : diff;
    pos_step    = tgt_above ? (pos_q + step) : (pos_q - step);
  end

  // Sequencer next state: accept, load target, then move once per enabled frame tick.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    tgt_d   = tgt_q;
    pos_d   = pos_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          angle_d = angle_clamp;
          state_d = StLoad;
        end
      end
      StLoad: begin
        tgt_d   = tgt_calc;
        state_d = (tgt_calc == pos_q) ? StIdle : StRamp;
      end
      StRamp: begin
        if (frame_tick && enable) begin
          pos_d = pos_step;
          if (pos_step == tgt_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Duty only changes on the frame wrap so the PWM never sees a partial pulse.
  always_comb begin
    duty_d = duty_q;
    if (frame_tick) begin
      duty_d = enable ? pos_d : 18'd0;
    end
  end

  // State registers with asynchronous reset to the rest position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 20'd0;
      state_q <= StIdle;
      angle_q <= 8'(RESET_ANGLE);
      pos_q   <= ResetPulse;
      tgt_q   <= ResetPulse;
      duty_q  <= ResetPulse;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      angle_q <= angle_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
    end
  end

  // Status outputs decoded from the sequencer state.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    at_target = (state_q == StIdle) && (pos_q == tgt_q);
    duty      = duty_q;
  end

endmodule

// File: tb/tb_servo_ctrl.sv
// Self-checking bench for servo_ctrl using a short frame (20 cycles) so full ramps stay fast.
// Expected duty words are queued per frame as stimulus is applied and compared at each wrap.
module tb_servo_ctrl;

  localparam int unsigned P         = 20;
  localparam int unsigned MINP      = 50_000;
  localparam int unsigned STEPW     = (100_000 - 50_000) / 180;
  localparam int unsigned SLEW      = 1_000;
  localparam logic [17:0] REST      = 18'(MINP + 90 * STEPW);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_angle = 8'd0;
  logic        cmd_ready;
  logic [17:0] duty;
  logic        busy;
  logic        at_target;
  logic        frame_tick;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_tick = 0;
  bit          have_prev = 1'b0;
  logic [17:0] m_pos;
  logic [17:0] exp_q[$];

  servo_ctrl #(
    .CLK_IN     (1000),
    .FREQ_SERVO (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_angle  (cmd_angle),
    .cmd_ready  (cmd_ready),
    .duty       (duty),
    .busy       (busy),
    .at_target  (at_target),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model_step(input logic [17:0] pos, input logic [17:0] tgt);
`ifdef SERVO_CTRL_SLEW_EN
    if (tgt > pos) return (tgt - pos > 18'(SLEW)) ? pos + 18'(SLEW) : tgt;
    else           return (pos - tgt > 18'(SLEW)) ? pos - 18'(SLEW) : tgt;
`else
    return tgt;
`endif
  endfunction

  function automatic logic [17:0] angle_to_pulse(input logic [7:0] ang);
    int a;
    a = (ang > 8'd180) ? 180 : int'(ang);
    return 18'(MINP + a * STEPW);
  endfunction

  // Called at a negedge; waits for the frame tick, then compares duty after the wrap edge.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < int'(P) + 4) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tick_seen"}, 32'(frame_tick), 32'd1);
    if (frame_tick === 1'b1) begin
      if (have_prev) check("tick_period", 32'(cyc - last_tick), 32'(P));
      last_tick = cyc;
      have_prev = 1'b1;
    end
    @(negedge clk);
    check("tick_width", 32'(frame_tick), 32'd0);
    if (exp_q.size() > 0) check(tag, 32'(duty), 32'(exp_q.pop_front()));
  endtask

  // Issues a moving command right after a frame wrap and follows it frame by frame.
  task automatic run_move(input logic [7:0] ang, input int dis_from, input int dis_cnt,
                          input string tag);
    logic [17:0] tgt;
    int f;
    tgt = angle_to_pulse(ang);
    cmd_angle = ang;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_not_at_target"}, 32'(at_target), 32'd0);
    // A command offered mid-move must be dropped.
    @(negedge clk);
    cmd_angle = 8'd0;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    f = 0;
    while (m_pos != tgt && f < 64) begin
      enable = !(f >= dis_from && f < dis_from + dis_cnt);
      if (enable) begin
        m_pos = model_step(m_pos, tgt);
        exp_q.push_back(m_pos);
      end else begin
        exp_q.push_back(18'd0);
      end
      wait_tick({tag, "_duty"});
      f++;
    end
    enable = 1'b1;
    check({tag, "_done_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done_idle"}, 32'(busy), 32'd0);
    check({tag, "_done_at_target"}, 32'(at_target), 32'd1);
  endtask

  initial begin
    m_pos = REST;
    repeat (2) @(negedge clk);
    check("rst_duty", 32'(duty), 32'(REST));
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_at_target", 32'(at_target), 32'd1);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    // Two idle frames at the rest position.
    exp_q.push_back(REST);
    exp_q.push_back(REST);
    wait_tick("idle0");
    wait_tick("idle1");

    // Out-of-range angle clamps to 180.
    run_move(8'd200, 99, 0, "clamp");
    check("clamp_final", 32'(duty), 32'(angle_to_pulse(8'd180)));

    // Same target again: LOAD returns straight to IDLE, duty unchanged.
    cmd_angle = 8'd180;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("same_load_busy", 32'(busy), 32'd1);
    check("same_load_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("same_idle_busy", 32'(busy), 32'd0);
    check("same_idle_ready", 32'(cmd_ready), 32'd1);
    check("same_at_target", 32'(at_target), 32'd1);
    exp_q.push_back(m_pos);
    wait_tick("same_duty");

    // Move to 0 with the servo released for three frames partway through.
    run_move(8'd0, 2, 3, "down");

    // Start a move while disabled, then reset in the middle of it.
    cmd_angle = 8'd180;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    enable = 1'b0;
    exp_q.push_back(18'd0);
    wait_tick("held_duty");
    check("held_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_duty", 32'(duty), 32'(REST));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_at_target", 32'(at_target), 32'd1);
    check("midrst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    have_prev = 1'b0;
    m_pos = REST;
    exp_q.push_back(REST);
    wait_tick("post_rst");

    run_move(8'd0, 99, 0, "to_zero");
    check("to_zero_final", 32'(duty), 32'(MINP));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
